cmp_sort_controller: RTL and testbench
======================================

Name: cmp_sort_controller

Overview:
- Sequencer that sorts a small buffer of 4-bit unsigned values into ascending order using one shared external 4-bit magnitude comparator.
- Load values over a valid/ready input, pulse start, then drain the sorted values over a valid/ready output.
- Uses a bubble sort with one comparison per cycle. The comparator stays outside this block; the block drives its operands and samples its less/greater/equal outputs in the same cycle.

Parameters:
- DEPTH, 8, buffer capacity in words; legal range 2..16.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  load word valid
- in_ready  output  1  block can accept a load word
- in_data  input  4  load word
- start  input  1  one-cycle pulse: begin sorting the loaded words
- busy  output  1  high in SORT and DRAIN
- done  output  1  one-cycle pulse after the last output word is accepted
- out_valid  output  1  sorted word valid
- out_ready  input  1  consumer accepts word
- out_data  output  4  sorted word
- out_last  output  1  high with the final sorted word
- cmp_a  output  4  comparator operand A
- cmp_b  output  4  comparator operand B
- cmp_less  input  1  comparator: A<B
- cmp_greater  input  1  comparator: A>B
- cmp_equal  input  1  comparator: A==B
- swap_count  output  8  swaps in current job, saturating at 255
- cmp_error  output  1  sticky: illegal comparator result seen

Behaviour:
- Reset values: state=LOAD, count=0, busy=0, done=0, out_valid=0, out_last=0, out_data=0, cmp_a=0, cmp_b=0, swap_count=0, cmp_error=0, in_ready=1. Buffer contents are don't-care.
- Reset mid-operation aborts the job and discards the buffer. No done pulse is issued.
- LOAD state:
  - in_ready = (count<DEPTH).
  - A word is accepted when in_valid&in_ready: mem[count]<=in_data, count++.
  - in_valid while full is ignored.
- start in LOAD:
  - If count==0, start is ignored and the block stays in LOAD.
  - Otherwise n is latched and swap_count clears. If a load word is accepted in the same cycle, n = count+1.
  - If n==1, go directly to DRAIN. Otherwise go to SORT with i=0, pass=0, swapped=0.
- start outside LOAD is ignored.
- SORT state:
  - in_ready=0.
  - Each cycle: cmp_a=mem[i], cmp_b=mem[i+1], both combinational from state.
  - If cmp_greater: swap mem[i] and mem[i+1] at the clock edge, set swapped, and increment swap_count (saturating).
  - Equal values are never swapped, so the sort is stable.
  - i runs 0..n-2-pass. At the last i of a pass:
    - Go to DRAIN if (no swap this pass, counting this cycle) or pass==n-2.
    - Otherwise pass++, i=0, swapped=0.
  - Sorting n values in descending order takes exactly n(n-1)/2 SORT cycles. An already sorted buffer takes n-1 cycles.
- Comparator check: in SORT, exactly one of less/greater/equal must be 1. If not, set cmp_error (cleared only by reset) and treat the compare as no-swap. Sorting continues.
- Outside SORT: cmp_a=cmp_b=0.
- DRAIN state:
  - out_valid=1, out_data=mem[rd], out_last=(rd==n-1).
  - rd advances on out_valid&out_ready.
  - out_data and out_last are held stable while out_ready=0.
  - On acceptance of the last word: next cycle done=1 for one cycle, count=0, state=LOAD, in_ready=1.
- busy=1 exactly in SORT and DRAIN.
- swap_count holds its value after the job until the next accepted start.

Test Plan:
- Descending load: load 7,6,5,4,3,2,1,0 (DEPTH=8), pulse start -> 28 SORT cycles; output 0..7 with out_last on 7; swap_count=28; done pulses once; in_ready returns to 1.
- Already sorted: load 1,2,3,4,5,6,7,8 -> 7 SORT cycles; output unchanged; swap_count=0.
- Edge counts and ignored starts:
  - start with count==0 -> stays LOAD, busy=0.
  - Load single value 9 and start -> DRAIN next cycle; out_data=9, out_last=1.
  - start in the same cycle as the first load word -> n=1.
- Duplicates and backpressure: load 5,3,5,0,15,3 (6 words) and drive out_ready with a 1-0-0-1 pattern -> outputs 0,3,3,5,5,15 with no drop or duplicate, data held while stalled.
- Full/overflow: assert in_valid with 10 words at DEPTH=8 -> only the first 8 accepted; in_ready=0 after the 8th.
- Reset and errors:
  - Assert reset mid-SORT -> next cycle all outputs at reset values, no done pulse; a new 3-word job then sorts correctly.
  - Force cmp_less=cmp_greater=1 for one SORT cycle -> cmp_error=1 and stays set; that pair is not swapped.

Source files
------------

// File: rtl/cmp_sort_if.sv
// Handshake, control and comparator bundle for cmp_sort_controller.
// The slave modport is the sorter's view; master is the surrounding system's view.
interface cmp_sort_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_last;
    logic [3:0] cmp_a;
    logic [3:0] cmp_b;
    logic       cmp_less;
    logic       cmp_greater;
    logic       cmp_equal;
    logic [7:0] swap_count;
    logic       cmp_error;

    modport slave (
        input  in_valid, in_data, start, out_ready, cmp_less, cmp_greater, cmp_equal,
        output in_ready, busy, done, out_valid, out_data, out_last, cmp_a, cmp_b,
               swap_count, cmp_error
    );

    modport master (
        output in_valid, in_data, start, out_ready, cmp_less, cmp_greater, cmp_equal,
        input  in_ready, busy, done, out_valid, out_data, out_last, cmp_a, cmp_b,
               swap_count, cmp_error
    );
endinterface

// File: rtl/cmp_sort_controller.sv
// Bubble-sort sequencer for 4-bit words: load, sort with one external compare per
// cycle, then drain ascending values over a valid/ready output.
module cmp_sort_controller #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    cmp_sort_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [DEPTH-1:0][3:0]   mem_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           n_q, n_d;
    logic [IW-1:0]           i_q, i_d;
    logic [IW-1:0]           pass_q, pass_d;
    logic [IW-1:0]           rd_q, rd_d;
    logic                    swapped_q, swapped_d;
    logic [7:0]              swc_q, swc_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;

    logic          load_acc, start_ok, cmp_ok, do_swap, last_i, sort_end;
    logic          out_acc, rd_last;
    logic [CW-1:0] n_start;
    logic [IW-1:0] i_nx;
    logic [3:0]    a_w, b_w;

    assign i_nx     = i_q + IW'(1);
    assign a_w      = mem_q[i_q];
    assign b_w      = mem_q[i_nx];
    assign load_acc = (state_q == S_LOAD) && bus.in_valid && (cnt_q < CW'(DEPTH));
    assign n_start  = cnt_q + CW'(load_acc);
    // A start alongside the first load word is a legal one-word job.
    assign start_ok = (state_q == S_LOAD) && bus.start && ((cnt_q != '0) || load_acc);
    assign cmp_ok   = ( bus.cmp_less & ~bus.cmp_greater & ~bus.cmp_equal) |
                      (~bus.cmp_less &  bus.cmp_greater & ~bus.cmp_equal) |
                      (~bus.cmp_less & ~bus.cmp_greater &  bus.cmp_equal);
    assign do_swap  = (state_q == S_SORT) && cmp_ok && bus.cmp_greater;
    assign last_i   = CW'(i_q) == (n_q - CW'(2) - CW'(pass_q));
    assign sort_end = last_i && (!(swapped_q || do_swap) || (CW'(pass_q) == n_q - CW'(2)));
    assign out_acc  = (state_q == S_DRAIN) && bus.out_ready;
    assign rd_last  = CW'(rd_q) == (n_q - CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_LOAD;
            cnt_q     <= '0;
            n_q       <= '0;
            i_q       <= '0;
            pass_q    <= '0;
            rd_q      <= '0;
            swapped_q <= 1'b0;
            swc_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            i_q       <= i_d;
            pass_q    <= pass_d;
            rd_q      <= rd_d;
            swapped_q <= swapped_d;
            swc_q     <= swc_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    // Buffer contents need no reset; load and swap never overlap.
    always_ff @(posedge clk) begin
        if (load_acc) mem_q[IW'(cnt_q)] <= bus.in_data;
        if (do_swap) begin
            mem_q[i_q]  <= b_w;
            mem_q[i_nx] <= a_w;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (start_ok) state_d = (n_start == CW'(1)) ? S_DRAIN : S_SORT;
            S_SORT:  if (sort_end) state_d = S_DRAIN;
            S_DRAIN: if (out_acc && rd_last) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        n_d       = n_q;
        i_d       = i_q;
        pass_d    = pass_q;
        rd_d      = rd_q;
        swapped_d = swapped_q;
        swc_d     = swc_q;
        err_d     = err_q;
        done_d    = out_acc && rd_last;
        if (load_acc) cnt_d = cnt_q + CW'(1);
        if (start_ok) begin
            n_d       = n_start;
            i_d       = '0;
            pass_d    = '0;
            rd_d      = '0;
            swapped_d = 1'b0;
            swc_d     = '0;
        end
        if (state_q == S_SORT) begin
            if (!cmp_ok) err_d = 1'b1;
            if (do_swap && swc_q != 8'hFF) swc_d = swc_q + 8'd1;
            if (last_i) begin
                i_d       = '0;
                pass_d    = pass_q + IW'(1);
                swapped_d = 1'b0;
            end else begin
                i_d       = i_nx;
                swapped_d = swapped_q | do_swap;
            end
        end
        if (out_acc) begin
            rd_d = rd_q + IW'(1);
            if (rd_last) cnt_d = '0;
        end
    end

    always_comb begin
        bus.in_ready   = 1'b0;
        bus.busy       = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_data   = '0;
        bus.out_last   = 1'b0;
        bus.cmp_a      = '0;
        bus.cmp_b      = '0;
        bus.done       = done_q;
        bus.swap_count = swc_q;
        bus.cmp_error  = err_q;
        case (state_q)
            S_LOAD:  bus.in_ready = cnt_q < CW'(DEPTH);
            S_SORT: begin
                bus.busy  = 1'b1;
                bus.cmp_a = a_w;
                bus.cmp_b = b_w;
            end
            S_DRAIN: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_data  = mem_q[rd_q];
                bus.out_last  = rd_last;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cmp_sort_controller.sv
// Directed bench: stimulus pushes expected words into a queue, a negedge monitor
// pops and compares every accepted output word.
module tb_cmp_sort_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic inj = 1'b0;
    always #5 clk = ~clk;

    cmp_sort_if bus();

    assign bus.cmp_less    = inj ? 1'b1 : (bus.cmp_a < bus.cmp_b);
    assign bus.cmp_greater = inj ? 1'b1 : (bus.cmp_a > bus.cmp_b);
    assign bus.cmp_equal   = inj ? 1'b0 : (bus.cmp_a == bus.cmp_b);

    cmp_sort_controller #(.DEPTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct { logic [3:0] d; logic l; } exp_t;
    exp_t exp_q[$];
    int vecs = 0;
    int errs = 0;
    int done_cnt = 0;
    logic [3:0] pat = 4'b1001;

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input bit l);
        exp_t e;
        e.d = 4'(d);
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic load_word(input int w);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'(w);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic sort_phase(input string nm, input int exp_cyc);
        int c = 0;
        while (bus.busy && !bus.out_valid && c < 200) begin
            tick();
            c++;
        end
        chk({nm, " sort cycles"}, c, exp_cyc);
        chk({nm, " drain valid"}, int'(bus.out_valid), 1);
    endtask

    task automatic drain(input string nm, input bit bp, input int exp_sw);
        int c = 0;
        int d0 = done_cnt;
        bit got = 1'b0;
        while (!got && c < 300) begin
            bus.out_ready = bp ? pat[c % 4] : 1'b1;
            tick();
            c++;
            if (bus.done) got = 1'b1;
        end
        bus.out_ready = 1'b0;
        chk({nm, " done seen"}, int'(got), 1);
        chk({nm, " in_ready after"}, int'(bus.in_ready), 1);
        chk({nm, " busy after"}, int'(bus.busy), 0);
        chk({nm, " swap_count"}, int'(bus.swap_count), exp_sw);
        tick();
        chk({nm, " done one cycle"}, int'(bus.done), 0);
        chk({nm, " done pulses"}, done_cnt - d0, 1);
        chk({nm, " pending words"}, exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " in_ready"}, int'(bus.in_ready), 1);
        chk({nm, " busy"}, int'(bus.busy), 0);
        chk({nm, " done"}, int'(bus.done), 0);
        chk({nm, " out_valid"}, int'(bus.out_valid), 0);
        chk({nm, " out_last"}, int'(bus.out_last), 0);
        chk({nm, " out_data"}, int'(bus.out_data), 0);
        chk({nm, " cmp_a"}, int'(bus.cmp_a), 0);
        chk({nm, " cmp_b"}, int'(bus.cmp_b), 0);
        chk({nm, " swap_count"}, int'(bus.swap_count), 0);
        chk({nm, " cmp_error"}, int'(bus.cmp_error), 0);
    endtask

    // Output monitor: compares accepted words and checks stall stability.
    initial begin
        bit stall = 1'b0;
        logic [3:0] hd = '0;
        logic hl = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) done_cnt++;
            if (stall && !reset) begin
                chk("hold valid", int'(bus.out_valid), 1);
                chk("hold data", int'(bus.out_data), int'(hd));
                chk("hold last", int'(bus.out_last), int'(hl));
            end
            stall = bus.out_valid && !bus.out_ready;
            hd = bus.out_data;
            hl = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected word: got %0d expected none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", int'(bus.out_data), int'(e.d));
                    chk("out_last", int'(bus.out_last), int'(e.l));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        // start with nothing loaded is ignored
        pulse_start();
        chk("empty start busy", int'(bus.busy), 0);
        chk("empty start in_ready", int'(bus.in_ready), 1);

        // descending input, worst case
        for (int k = 0; k < 8; k++) load_word(7 - k);
        for (int k = 0; k < 8; k++) push(k, k == 7);
        pulse_start();
        chk("desc cmp_a", int'(bus.cmp_a), 7);
        chk("desc cmp_b", int'(bus.cmp_b), 6);
        sort_phase("desc", 28);
        drain("desc", 1'b0, 28);

        // already sorted
        for (int k = 0; k < 8; k++) load_word(k + 1);
        for (int k = 0; k < 8; k++) push(k + 1, k == 7);
        pulse_start();
        sort_phase("sorted", 7);
        drain("sorted", 1'b0, 0);

        // single word
        load_word(9);
        push(9, 1'b1);
        pulse_start();
        sort_phase("single", 0);
        drain("single", 1'b0, 0);

        // start together with the first load word
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hA;
        bus.start    = 1'b1;
        push(10, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        sort_phase("same-cycle", 0);
        drain("same-cycle", 1'b0, 0);

        // duplicates with backpressure
        load_word(5); load_word(3); load_word(5);
        load_word(0); load_word(15); load_word(3);
        push(0, 0); push(3, 0); push(3, 0); push(5, 0); push(5, 0); push(15, 1);
        pulse_start();
        sort_phase("dup", 14);
        drain("dup", 1'b1, 7);

        // overflow: 10 offered, 8 taken
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(12 - k);
            @(negedge clk);
            if (bus.in_ready) acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("overflow accepted", acc, 8);
        chk("overflow in_ready", int'(bus.in_ready), 0);
        for (int k = 0; k < 8; k++) push(5 + k, k == 7);
        pulse_start();
        sort_phase("overflow", 28);
        drain("overflow", 1'b0, 28);

        // reset mid-sort aborts the job
        for (int k = 0; k < 8; k++) load_word(7 - k);
        pulse_start();
        tick(); tick(); tick();
        acc = done_cnt;
        reset = 1'b1;
        tick();
        chk_reset_vals("midsort reset");
        reset = 1'b0;
        tick(); tick();
        chk("midsort no done", done_cnt - acc, 0);
        load_word(2); load_word(0); load_word(1);
        push(0, 0); push(1, 0); push(2, 1);
        pulse_start();
        sort_phase("post-reset", 3);
        drain("post-reset", 1'b0, 2);

        // illegal comparator result on the first compare: no swap, sticky error
        load_word(3); load_word(1); load_word(2);
        push(3, 0); push(1, 0); push(2, 1);
        pulse_start();
        chk("err before", int'(bus.cmp_error), 0);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("err set", int'(bus.cmp_error), 1);
        sort_phase("err", 1);
        drain("err", 1'b0, 0);
        chk("err sticky", int'(bus.cmp_error), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("err cleared", int'(bus.cmp_error), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
